// File: rtl/ddr_init_sequencer_pkg.sv
// ddr_init_sequencer_pkg
//    Shared definitions for the DDR power-up initialisation sequencer:
//    sequencer states, SDRAM command encodings ({cs_n,ras_n,cas_n,we_n}),
//    mode-register bit positions and a small helper for sizing counters.
//    No ports; imported by the sequencer, its interface users and the timer.
package ddr_init_sequencer_pkg;

    typedef enum logic [3:0] {
        S_PWR,
        S_CKE,
        S_PRE1,
        S_EMR,
        S_MRDLL,
        S_PRE2,
        S_REF1,
        S_REF2,
        S_MR,
        S_DLL,
        S_DONE
    } state_e;

    localparam logic [3:0] CMD_NOP          = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
    localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;
    localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;

    // addr bit that selects "all banks" on PRECHARGE, and the mode-register DLL reset bit
    localparam int PRE_ALL_BANKS_BIT = 10;
    localparam int MR_DLL_RESET_BIT  = 8;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr_init_sequencer_if.sv
// ddr_init_sequencer_if
//    SDRAM command bus driven by the init sequencer during power-up.
//    Signals:
//       cke                      SDRAM clock enable
//       cs_n/ras_n/cas_n/we_n    command strobes
//       ba[1:0]                  bank address
//       addr[ROW_WIDTH-1:0]      address bus
//       init_done                init complete, hands the bus to the controller mux
//    Modports: master (sequencer drives), slave (mux / observer receives).
interface ddr_init_sequencer_if #(
    parameter int ROW_WIDTH = 13
);
    logic                 cke;
    logic                 cs_n;
    logic                 ras_n;
    logic                 cas_n;
    logic                 we_n;
    logic [1:0]           ba;
    logic [ROW_WIDTH-1:0] addr;
    logic                 init_done;

    modport master (
        output cke, cs_n, ras_n, cas_n, we_n, ba, addr, init_done
    );

    modport slave (
        input cke, cs_n, ras_n, cas_n, we_n, ba, addr, init_done
    );
endinterface

// File: rtl/ddr_wait_timer.sv
// ddr_wait_timer
//    Loadable down-counter with a zero flag. Loading takes priority over
//    counting; the count stops at zero rather than wrapping.
//    Ports:
//       clk       clock
//       rst_n     asynchronous active-low reset (count cleared to 0)
//       load_i    load value_i on the next clock
//       value_i   value to load
//       zero_o    count is currently zero
module ddr_wait_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    // Count down towards zero and park there until the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= value_i;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/ddr_init_sequencer.sv
// ddr_init_sequencer
//    Power-up initialisation sequencer for the DDR SDRAM. After reset it holds
//    CKE low for PWR_CYCLES, raises CKE, then issues PRECHARGE-all, LOAD MODE
//    (EMR), LOAD MODE (MR with DLL reset), PRECHARGE-all, two AUTO REFRESHes and
//    LOAD MODE (MR without DLL reset), waits DLL_CYCLES and raises init_done.
//    Every output is registered.
//    Ports:
//       clk       highspeed_clk_0
//       reset_n   asynchronous active-low reset
//       cmdBus    command bus (master modport): cke, cs_n, ras_n, cas_n, we_n,
//                 ba, addr, init_done
module ddr_init_sequencer
    import ddr_init_sequencer_pkg::*;
#(
    parameter int                   PWR_CYCLES = 20000,
    parameter int                   T_RP       = 2,
    parameter int                   T_MRD      = 2,
    parameter int                   T_RFC      = 8,
    parameter int                   DLL_CYCLES = 200,
    parameter int                   ROW_WIDTH  = 13,
    parameter logic [ROW_WIDTH-1:0] MR_VALUE   = 'h021,
    parameter logic [ROW_WIDTH-1:0] EMR_VALUE  = 'h000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ddr_init_sequencer_if.master  cmdBus
);

    localparam int MAX_WAIT = maxOf(maxOf(maxOf(PWR_CYCLES, T_RP), maxOf(T_MRD, T_RFC)), DLL_CYCLES);
    localparam int CW       = $clog2(MAX_WAIT + 1);

    // The counter leaves reset at zero, so the first S_PWR cycle is spent
    // arming it with the remainder of the power-up wait.
    localparam logic [CW-1:0] PWR_LOAD = (PWR_CYCLES >= 2) ? CW'(PWR_CYCLES - 2) : '0;

    localparam logic [ROW_WIDTH-1:0] ONE_ADDR     = {{(ROW_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ROW_WIDTH-1:0] PRE_ALL_ADDR = ONE_ADDR << PRE_ALL_BANKS_BIT;
    localparam logic [ROW_WIDTH-1:0] DLL_RST_MASK = ONE_ADDR << MR_DLL_RESET_BIT;

    state_e               state_q, state_d, stateSucc;
    logic                 pwrArmed_q;
    logic                 cke_q;
    logic [3:0]           cmd_q;
    logic [1:0]           ba_q;
    logic [ROW_WIDTH-1:0] addr_q;
    logic                 initDone_q;

    logic                 advance;
    logic                 timerZero;
    logic                 timerLoad;
    logic [CW-1:0]        timerValue;
    int                   waitCycles;

    ddr_wait_timer #(.WIDTH(CW)) waitTimer (
        .clk     (clk),
        .rst_n   (reset_n),
        .load_i  (timerLoad),
        .value_i (timerValue),
        .zero_o  (timerZero)
    );

    // Fixed order of the init sequence; S_DONE is terminal.
    always_comb begin
        stateSucc = state_q;
        unique case (state_q)
            S_PWR:   stateSucc = S_CKE;
            S_CKE:   stateSucc = S_PRE1;
            S_PRE1:  stateSucc = S_EMR;
            S_EMR:   stateSucc = S_MRDLL;
            S_MRDLL: stateSucc = S_PRE2;
            S_PRE2:  stateSucc = S_REF1;
            S_REF1:  stateSucc = S_REF2;
            S_REF2:  stateSucc = S_MR;
            S_MR:    stateSucc = S_DLL;
            S_DLL:   stateSucc = S_DONE;
            S_DONE:  stateSucc = S_DONE;
        endcase
    end

    // Number of cycles spent in the state being entered, counted from its command.
    always_comb begin
        waitCycles = 1;
        case (stateSucc)
            S_PRE1, S_PRE2:        waitCycles = T_RP;
            S_EMR, S_MRDLL, S_MR:  waitCycles = T_MRD;
            S_REF1, S_REF2:        waitCycles = T_RFC;
            S_DLL:                 waitCycles = DLL_CYCLES;
            default:               waitCycles = 1;
        endcase
    end

    // Advance once the wait for the current state has run out; the timer is
    // reloaded on every advance and once when arming the power-up wait.
    always_comb begin
        advance = 1'b0;
        if (state_q == S_PWR) begin
            advance = (PWR_CYCLES == 1) || (pwrArmed_q && timerZero);
        end else if (state_q != S_DONE) begin
            advance = timerZero;
        end
        state_d    = advance ? stateSucc : state_q;
        timerLoad  = advance || ((state_q == S_PWR) && !pwrArmed_q);
        timerValue = advance ? CW'(waitCycles - 1) : PWR_LOAD;
    end

    // Sequencer FSM with registered outputs. A command is driven only in the
    // cycle its state is entered; every other cycle is NOP with ba/addr held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_PWR;
            pwrArmed_q <= 1'b0;
            cke_q      <= 1'b0;
            cmd_q      <= CMD_NOP;
            ba_q       <= 2'b00;
            addr_q     <= '0;
            initDone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= CMD_NOP;
            if (state_q == S_PWR) begin
                pwrArmed_q <= 1'b1;
            end
            if (advance) begin
                case (stateSucc)
                    S_CKE: begin
                        cke_q <= 1'b1;
                    end
                    S_PRE1, S_PRE2: begin
                        cmd_q  <= CMD_PRECHARGE;
                        ba_q   <= 2'b00;
                        addr_q <= PRE_ALL_ADDR;
                    end
                    S_EMR: begin
                        cmd_q  <= CMD_LOAD_MODE;
                        ba_q   <= 2'b01;
                        addr_q <= EMR_VALUE;
                    end
                    S_MRDLL: begin
                        cmd_q  <= CMD_LOAD_MODE;
                        ba_q   <= 2'b00;
                        addr_q <= MR_VALUE | DLL_RST_MASK;
                    end
                    S_REF1, S_REF2: begin
                        cmd_q <= CMD_AUTO_REFRESH;
                    end
                    S_MR: begin
                        cmd_q  <= CMD_LOAD_MODE;
                        ba_q   <= 2'b00;
                        addr_q <= MR_VALUE & ~DLL_RST_MASK;
                    end
                    S_DONE: begin
                        initDone_q <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign cmdBus.cke       = cke_q;
    assign cmdBus.cs_n      = cmd_q[3];
    assign cmdBus.ras_n     = cmd_q[2];
    assign cmdBus.cas_n     = cmd_q[1];
    assign cmdBus.we_n      = cmd_q[0];
    assign cmdBus.ba        = ba_q;
    assign cmdBus.addr      = addr_q;
    assign cmdBus.init_done = initDone_q;

endmodule

// File: tb/tb_ddr_init_sequencer.sv
// tb_ddr_init_sequencer
//    Bench for ddr_init_sequencer. Two instances share one reset: dutA with
//    short test timings and dutB with every timing at its minimum of 1. A
//    timeline model gives the expected bus contents for any cycle count since
//    reset release; a negedge process compares both DUTs against it every
//    cycle, and recorded command/CKE/init_done times are pinned to literals.
module tb_ddr_init_sequencer;

    localparam int PWR  = 10;
    localparam int TRP  = 2;
    localparam int TMRD = 2;
    localparam int TRFC = 4;
    localparam int TDLL = 5;

    localparam logic [12:0] MRV  = 13'h021;
    localparam logic [12:0] EMRV = 13'h000;

    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] LMR  = 4'b0000;
    localparam logic [3:0] AREF = 4'b0001;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;

    int cmdTimesA[$];
    int cmdTimesB[$];
    int ckeRiseA  = -1;
    int ckeRiseB  = -1;
    int doneRiseA = -1;
    int doneRiseB = -1;

    ddr_init_sequencer_if #(.ROW_WIDTH(13)) busA ();
    ddr_init_sequencer_if #(.ROW_WIDTH(13)) busB ();

    ddr_init_sequencer #(
        .PWR_CYCLES (PWR),
        .T_RP       (TRP),
        .T_MRD      (TMRD),
        .T_RFC      (TRFC),
        .DLL_CYCLES (TDLL),
        .ROW_WIDTH  (13),
        .MR_VALUE   (MRV),
        .EMR_VALUE  (EMRV)
    ) dutA (
        .clk     (clk),
        .reset_n (reset_n),
        .cmdBus  (busA)
    );

    ddr_init_sequencer #(
        .PWR_CYCLES (1),
        .T_RP       (1),
        .T_MRD      (1),
        .T_RFC      (1),
        .DLL_CYCLES (1),
        .ROW_WIDTH  (13),
        .MR_VALUE   (MRV),
        .EMR_VALUE  (EMRV)
    ) dutB (
        .clk     (clk),
        .reset_n (reset_n),
        .cmdBus  (busB)
    );

    always #5 clk = ~clk;

    // Cycles since reset release: the first posedge after release is cycle 1.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle = 0;
            cmdTimesA.delete();
            cmdTimesB.delete();
            ckeRiseA  = -1;
            ckeRiseB  = -1;
            doneRiseA = -1;
            doneRiseB = -1;
        end else begin
            cycle = cycle + 1;
        end
    end

    task automatic compare(input string name, input logic [15:0] actual, input logic [15:0] expected);
        compared = compared + 1;
        if (actual !== expected) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycle, actual, expected);
        end
    endtask

    // Expected bus for cycle n: CKE rises after pwr cycles, one NOP cycle with
    // CKE high, then the seven commands at their cumulative spacings.
    function automatic void model(input int n, input int pwr, input int rp, input int mrd,
                                  input int rfc, input int dll,
                                  output logic eCke, output logic [3:0] eCmd,
                                  output logic chkBa, output logic [1:0] eBa,
                                  output logic [12:0] eAddr, output logic [12:0] eMask,
                                  output logic eDone);
        int t;
        eCke  = (n >= pwr);
        eDone = (n >= pwr + 1 + 2*rp + 3*mrd + 2*rfc + dll);
        eCmd  = NOP;
        chkBa = 1'b0;
        eBa   = 2'b00;
        eAddr = '0;
        eMask = '0;
        t = pwr + 1;
        for (int k = 0; k < 7; k++) begin
            if (n == t) begin
                case (k)
                    0, 3: begin eCmd = PRE;  eAddr = 13'h400; eMask = 13'h400; end
                    1:    begin eCmd = LMR;  chkBa = 1'b1; eBa = 2'b01; eAddr = EMRV; eMask = '1; end
                    2:    begin eCmd = LMR;  chkBa = 1'b1; eBa = 2'b00; eAddr = MRV | 13'h100; eMask = '1; end
                    6:    begin eCmd = LMR;  chkBa = 1'b1; eBa = 2'b00; eAddr = MRV & ~13'h100; eMask = '1; end
                    default: eCmd = AREF;
                endcase
            end
            case (k)
                0, 3:    t = t + rp;
                1, 2, 6: t = t + mrd;
                default: t = t + rfc;
            endcase
        end
    endfunction

    task automatic checkOutput(input string tag, input logic cke, input logic [3:0] cmd,
                               input logic [1:0] ba, input logic [12:0] addr, input logic done,
                               input int pwr, input int rp, input int mrd, input int rfc, input int dll);
        logic        eCke, eDone, chkBa;
        logic [3:0]  eCmd;
        logic [1:0]  eBa;
        logic [12:0] eAddr, eMask;
        if (!reset_n) begin
            eCke = 1'b0; eCmd = NOP; chkBa = 1'b1; eBa = 2'b00;
            eAddr = '0; eMask = '1; eDone = 1'b0;
        end else begin
            model(cycle, pwr, rp, mrd, rfc, dll, eCke, eCmd, chkBa, eBa, eAddr, eMask, eDone);
        end
        compare({tag, ".cke"}, 16'(cke), 16'(eCke));
        compare({tag, ".cmd"}, 16'(cmd), 16'(eCmd));
        compare({tag, ".init_done"}, 16'(done), 16'(eDone));
        if (chkBa) compare({tag, ".ba"}, 16'(ba), 16'(eBa));
        if (eMask != '0) compare({tag, ".addr"}, 16'(addr & eMask), 16'(eAddr));
    endtask

    // Per-cycle compare, away from the active edge, plus event-time recording.
    always @(negedge clk) begin
        checkOutput("A", busA.cke, {busA.cs_n, busA.ras_n, busA.cas_n, busA.we_n},
                    busA.ba, busA.addr, busA.init_done, PWR, TRP, TMRD, TRFC, TDLL);
        checkOutput("B", busB.cke, {busB.cs_n, busB.ras_n, busB.cas_n, busB.we_n},
                    busB.ba, busB.addr, busB.init_done, 1, 1, 1, 1, 1);
        if (reset_n) begin
            if ({busA.cs_n, busA.ras_n, busA.cas_n, busA.we_n} != NOP) cmdTimesA.push_back(cycle);
            if ({busB.cs_n, busB.ras_n, busB.cas_n, busB.we_n} != NOP) cmdTimesB.push_back(cycle);
            if (busA.cke && ckeRiseA < 0) ckeRiseA = cycle;
            if (busB.cke && ckeRiseB < 0) ckeRiseB = cycle;
            if (busA.init_done && doneRiseA < 0) doneRiseA = cycle;
            if (busB.init_done && doneRiseB < 0) doneRiseB = cycle;
        end
    end

    // Hand-computed event times for a complete run since the last reset release.
    task automatic checkPins();
        int expA[7] = '{11, 13, 15, 17, 19, 23, 27};
        int expB[7] = '{2, 3, 4, 5, 6, 7, 8};
        compare("A.cmdCount", 16'(cmdTimesA.size()), 16'd7);
        compare("B.cmdCount", 16'(cmdTimesB.size()), 16'd7);
        for (int k = 0; k < 7; k++) begin
            compare("A.cmdTime", (k < cmdTimesA.size()) ? 16'(cmdTimesA[k]) : 16'hffff, 16'(expA[k]));
            compare("B.cmdTime", (k < cmdTimesB.size()) ? 16'(cmdTimesB[k]) : 16'hffff, 16'(expB[k]));
        end
        compare("A.ckeRise", 16'(ckeRiseA), 16'd10);
        compare("B.ckeRise", 16'(ckeRiseB), 16'd1);
        compare("A.doneRise", 16'(doneRiseA), 16'd34);
        compare("B.doneRise", 16'(doneRiseB), 16'd10);
    endtask

    // Assert reset shortly after a posedge, hold it for holdCycles clocks (0 =
    // a glitch within one cycle), release it, then run runCycles clocks.
    task automatic applyStimulus(input int holdCycles, input int runCycles);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        if (holdCycles == 0) begin
            #2;
        end else begin
            repeat (holdCycles) @(posedge clk);
            #2;
        end
        reset_n = 1'b1;
        repeat (runCycles) @(posedge clk);
    endtask

    initial begin
        #1;
        reset_n = 1'b0;

        $display("[TB] full sequence after a 3-cycle reset");
        applyStimulus(3, 40);
        #1;
        checkPins();

        $display("[TB] reset pulse while in the first AUTO REFRESH wait");
        applyStimulus(2, 20);
        applyStimulus(1, 40);
        #1;
        checkPins();

        $display("[TB] random reset lengths and abort points");
        for (int trial = 0; trial < 8; trial++) begin
            applyStimulus(int'($urandom_range(0, 4)), int'($urandom_range(1, 45)));
        end

        $display("[TB] long run after init_done");
        applyStimulus(1, 34 + 1000);
        #1;
        checkPins();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
